// File: rtl/sl_channel_ctrl_if.sv
// Handshake/status bundle between the SL channel direction controller and
// the transmitter, receiver and channel pads it coordinates.
interface sl_channel_ctrl_if;
  logic       tx_req;
  logic       tx_done;
  logic       rx_enable;
  logic       loopback_en;
  logic       sl_zeroes_in;
  logic       sl_ones_in;
  logic       trans_active;
  logic       rec_active;
  logic       tx_grant;
  logic       tx_fail;
  logic [2:0] state_o;

  // Requesting side: transmitter, receiver, test control and line readback.
  modport master (
    output tx_req, tx_done, rx_enable, loopback_en, sl_zeroes_in, sl_ones_in,
    input  trans_active, rec_active, tx_grant, tx_fail, state_o
  );

  // Controller side.
  modport slave (
    input  tx_req, tx_done, rx_enable, loopback_en, sl_zeroes_in, sl_ones_in,
    output trans_active, rec_active, tx_grant, tx_fail, state_o
  );
endinterface

// File: rtl/sl_channel_ctrl.sv
// Direction controller for the half-duplex two-wire SL channel.
// Decides who owns the zeroes/ones pair: local transmitter, receiver or the
// internal loopback path. The line is only driven after a run of idle samples,
// and a guard gap with both drivers released follows every driving period.
module sl_channel_ctrl #(
  parameter int IDLE_CYCLES    = 8,
  parameter int GUARD_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  sl_channel_ctrl_if.slave   ch
);

  localparam int IW = $clog2(IDLE_CYCLES + 1);
  localparam int GW = $clog2(GUARD_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [IW-1:0] IDLE_MAX  = IW'(IDLE_CYCLES);
  localparam logic [GW-1:0] GUARD_MAX = GW'(GUARD_CYCLES);
  localparam logic [TW-1:0] TMO_MAX   = TW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    ST_OFF       = 3'd0,
    ST_LISTEN    = 3'd1,
    ST_WAIT_IDLE = 3'd2,
    ST_TX        = 3'd3,
    ST_TURN      = 3'd4,
    ST_LOOP      = 3'd5
  } state_e;

  // Synchronizer flops; idle line (both wires high) is the reset value so a
  // reset never fabricates a busy line.
  logic zeroes_meta_q, zeroes_sync_q;
  logic ones_meta_q, ones_sync_q;
  logic line_idle_s;

  state_e        state_q, state_d;
  logic [IW-1:0] idle_cnt_q, idle_cnt_d, idle_step_s;
  logic [GW-1:0] guard_cnt_q, guard_cnt_d, guard_step_s;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d, tmo_step_s;

  logic trans_active_q, trans_active_d;
  logic rec_active_q, rec_active_d;
  logic tx_grant_q, tx_grant_d;
  logic tx_fail_q, tx_fail_d;

  // Shared arbitration: loopback beats transmit beats receive.
  function automatic state_e dispatch(input logic lb, input logic tx, input logic rx);
    if (lb) begin
      return ST_LOOP;
    end else if (tx) begin
      return ST_WAIT_IDLE;
    end else if (rx) begin
      return ST_LISTEN;
    end else begin
      return ST_OFF;
    end
  endfunction

  // Two-flop synchronizer for the raw channel readback wires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zeroes_meta_q <= 1'b1;
      zeroes_sync_q <= 1'b1;
      ones_meta_q   <= 1'b1;
      ones_sync_q   <= 1'b1;
    end else begin
      zeroes_meta_q <= ch.sl_zeroes_in;
      zeroes_sync_q <= zeroes_meta_q;
      ones_meta_q   <= ch.sl_ones_in;
      ones_sync_q   <= ones_meta_q;
    end
  end

  assign line_idle_s = zeroes_sync_q & ones_sync_q;

  // Next-state, counter and output decode; outputs follow the next state so
  // they switch on the same edge as the state register.
  always_comb begin
    state_d   = state_q;
    tx_fail_d = 1'b0;

    // Saturating increments; the idle run restarts on any busy sample.
    if (idle_cnt_q == IDLE_MAX) begin
      idle_step_s = idle_cnt_q;
    end else begin
      idle_step_s = idle_cnt_q + IW'(1);
    end
    if (!line_idle_s) begin
      idle_step_s = {IW{1'b0}};
    end else begin
      idle_step_s = idle_step_s;
    end
    if (guard_cnt_q == GUARD_MAX) begin
      guard_step_s = guard_cnt_q;
    end else begin
      guard_step_s = guard_cnt_q + GW'(1);
    end
    if (tmo_cnt_q == TMO_MAX) begin
      tmo_step_s = tmo_cnt_q;
    end else begin
      tmo_step_s = tmo_cnt_q + TW'(1);
    end

    case (state_q)
      ST_OFF, ST_LISTEN: begin
        state_d = dispatch(ch.loopback_en, ch.tx_req, ch.rx_enable);
      end
      ST_WAIT_IDLE: begin
        if (ch.loopback_en) begin
          state_d = ST_LOOP;
        end else if (!ch.tx_req) begin
          state_d = dispatch(1'b0, 1'b0, ch.rx_enable);
        end else if (idle_step_s == IDLE_MAX) begin
          // Idle completion wins over a simultaneous timeout.
          state_d = ST_TX;
        end else if (tmo_step_s == TMO_MAX) begin
          // Give up; the still-held tx_req is ignored for this one decision.
          tx_fail_d = 1'b1;
          state_d   = dispatch(1'b0, 1'b0, ch.rx_enable);
        end else begin
          state_d = ST_WAIT_IDLE;
        end
      end
      ST_TX: begin
        if (ch.tx_done || !ch.tx_req) begin
          state_d = ST_TURN;
        end else begin
          state_d = ST_TX;
        end
      end
      ST_LOOP: begin
        if (!ch.loopback_en) begin
          state_d = ST_TURN;
        end else begin
          state_d = ST_LOOP;
        end
      end
      ST_TURN: begin
        if (guard_step_s == GUARD_MAX) begin
          state_d = dispatch(ch.loopback_en, ch.tx_req, ch.rx_enable);
        end else begin
          state_d = ST_TURN;
        end
      end
      default: begin
        state_d = ST_OFF;
      end
    endcase

    // Counters only run while the state is held; any entry starts them at 0.
    if ((state_q == ST_WAIT_IDLE) && (state_d == ST_WAIT_IDLE)) begin
      idle_cnt_d = idle_step_s;
      tmo_cnt_d  = tmo_step_s;
    end else begin
      idle_cnt_d = {IW{1'b0}};
      tmo_cnt_d  = {TW{1'b0}};
    end
    if ((state_q == ST_TURN) && (state_d == ST_TURN)) begin
      guard_cnt_d = guard_step_s;
    end else begin
      guard_cnt_d = {GW{1'b0}};
    end

    case (state_d)
      ST_OFF: begin
        trans_active_d = 1'b0; rec_active_d = 1'b0;         tx_grant_d = 1'b0;
      end
      ST_LISTEN: begin
        trans_active_d = 1'b0; rec_active_d = 1'b1;         tx_grant_d = 1'b0;
      end
      ST_WAIT_IDLE: begin
        trans_active_d = 1'b0; rec_active_d = ch.rx_enable; tx_grant_d = 1'b0;
      end
      ST_TX: begin
        trans_active_d = 1'b1; rec_active_d = 1'b0;         tx_grant_d = 1'b1;
      end
      ST_TURN: begin
        trans_active_d = 1'b0; rec_active_d = 1'b0;         tx_grant_d = 1'b0;
      end
      ST_LOOP: begin
        trans_active_d = 1'b1; rec_active_d = 1'b1;         tx_grant_d = 1'b1;
      end
      default: begin
        trans_active_d = 1'b0; rec_active_d = 1'b0;         tx_grant_d = 1'b0;
      end
    endcase
  end

  // State, counters and registered outputs; reset releases the line at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_OFF;
      idle_cnt_q     <= {IW{1'b0}};
      guard_cnt_q    <= {GW{1'b0}};
      tmo_cnt_q      <= {TW{1'b0}};
      trans_active_q <= 1'b0;
      rec_active_q   <= 1'b0;
      tx_grant_q     <= 1'b0;
      tx_fail_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      idle_cnt_q     <= idle_cnt_d;
      guard_cnt_q    <= guard_cnt_d;
      tmo_cnt_q      <= tmo_cnt_d;
      trans_active_q <= trans_active_d;
      rec_active_q   <= rec_active_d;
      tx_grant_q     <= tx_grant_d;
      tx_fail_q      <= tx_fail_d;
    end
  end

  assign ch.trans_active = trans_active_q;
  assign ch.rec_active   = rec_active_q;
  assign ch.tx_grant     = tx_grant_q;
  assign ch.tx_fail      = tx_fail_q;
  assign ch.state_o      = state_q;

endmodule

// File: tb/tb_sl_channel_ctrl.sv
// Directed bench for sl_channel_ctrl with IDLE=8, GUARD=4, TIMEOUT=1024.
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
module tb_sl_channel_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  sl_channel_ctrl_if ch();

  sl_channel_ctrl #(
    .IDLE_CYCLES(8),
    .GUARD_CYCLES(4),
    .TIMEOUT_CYCLES(1024)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ch    (ch)
  );

  // Free-running 100 MHz-style clock.
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ch.tx_req = 1'b0; ch.tx_done = 1'b0; ch.rx_enable = 1'b1; ch.loopback_en = 1'b0;
    ch.sl_zeroes_in = 1'b1; ch.sl_ones_in = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (ch.state_o !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", ch.state_o); end
    n_checks++;
    if ({ch.trans_active, ch.rec_active, ch.tx_grant} !== 3'b000) begin
      n_fail++; $display("FAIL reset_sel: got %b expected 000", {ch.trans_active, ch.rec_active, ch.tx_grant});
    end
    n_checks++;
    if (ch.tx_fail !== 1'b0) begin n_fail++; $display("FAIL reset_txfail: got %b expected 0", ch.tx_fail); end
  endtask

  task automatic test_listen();
    rst_n = 1'b1;
    n_checks++;
    if (ch.state_o !== 3'd0) begin n_fail++; $display("FAIL release_state: got %0d expected 0", ch.state_o); end
    tick();
    n_checks++;
    if (ch.state_o !== 3'd1) begin n_fail++; $display("FAIL listen_state: got %0d expected 1", ch.state_o); end
    n_checks++;
    if ({ch.trans_active, ch.rec_active, ch.tx_grant} !== 3'b010) begin
      n_fail++; $display("FAIL listen_sel: got %b expected 010", {ch.trans_active, ch.rec_active, ch.tx_grant});
    end
  endtask

  task automatic test_tx();
    ch.tx_req = 1'b1;
    tick();
    n_checks++;
    if (ch.state_o !== 3'd2 || {ch.trans_active, ch.rec_active, ch.tx_grant} !== 3'b010) begin
      n_fail++; $display("FAIL wait_entry: got state %0d sel %b expected 2 010", ch.state_o, {ch.trans_active, ch.rec_active, ch.tx_grant});
    end
    repeat (7) tick();
    n_checks++;
    if (ch.state_o !== 3'd2 || ch.trans_active !== 1'b0) begin
      n_fail++; $display("FAIL idle7_wait: got state %0d ta %b expected 2 0", ch.state_o, ch.trans_active);
    end
    tick();
    n_checks++;
    if (ch.state_o !== 3'd3 || {ch.trans_active, ch.rec_active, ch.tx_grant} !== 3'b101) begin
      n_fail++; $display("FAIL idle8_tx: got state %0d sel %b expected 3 101", ch.state_o, {ch.trans_active, ch.rec_active, ch.tx_grant});
    end
    repeat (3) tick();
    n_checks++;
    if (ch.state_o !== 3'd3) begin n_fail++; $display("FAIL tx_hold: got %0d expected 3", ch.state_o); end
    ch.tx_done = 1'b1;
    tick();
    ch.tx_done = 1'b0; ch.tx_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (ch.state_o !== 3'd4 || {ch.trans_active, ch.rec_active, ch.tx_grant} !== 3'b000) begin
        n_fail++; $display("FAIL turn_guard[%0d]: got state %0d sel %b expected 4 000", i, ch.state_o, {ch.trans_active, ch.rec_active, ch.tx_grant});
      end
      tick();
    end
    n_checks++;
    if (ch.state_o !== 3'd1 || {ch.trans_active, ch.rec_active, ch.tx_grant} !== 3'b010) begin
      n_fail++; $display("FAIL turn_to_listen: got state %0d sel %b expected 1 010", ch.state_o, {ch.trans_active, ch.rec_active, ch.tx_grant});
    end
  endtask

  task automatic test_idle_restart();
    ch.tx_req = 1'b1;
    tick();
    repeat (4) tick();
    ch.sl_zeroes_in = 1'b0;
    tick();
    ch.sl_zeroes_in = 1'b1;
    // The busy sample is counted two edges later, so the run restarts then.
    repeat (3) tick();
    n_checks++;
    if (ch.state_o !== 3'd2) begin n_fail++; $display("FAIL restart_no_early_tx: got %0d expected 2", ch.state_o); end
    repeat (6) tick();
    n_checks++;
    if (ch.state_o !== 3'd2 || ch.trans_active !== 1'b0) begin
      n_fail++; $display("FAIL restart_7idle: got state %0d ta %b expected 2 0", ch.state_o, ch.trans_active);
    end
    tick();
    n_checks++;
    if (ch.state_o !== 3'd3 || ch.tx_grant !== 1'b1) begin
      n_fail++; $display("FAIL restart_8idle_tx: got state %0d grant %b expected 3 1", ch.state_o, ch.tx_grant);
    end
    ch.tx_req = 1'b0;
    tick();
    n_checks++;
    if (ch.state_o !== 3'd4) begin n_fail++; $display("FAIL txreq_drop_turn: got %0d expected 4", ch.state_o); end
    repeat (4) tick();
    n_checks++;
    if (ch.state_o !== 3'd1) begin n_fail++; $display("FAIL restart_back_listen: got %0d expected 1", ch.state_o); end
  endtask

  task automatic test_timeout();
    bit bad = 1'b0;
    ch.sl_zeroes_in = 1'b0;
    repeat (2) tick();
    ch.tx_req = 1'b1;
    tick();
    for (int i = 1; i <= 1023; i++) begin
      tick();
      if (ch.trans_active !== 1'b0 || ch.tx_fail !== 1'b0 || ch.state_o !== 3'd2) bad = 1'b1;
    end
    n_checks++;
    if (bad) begin n_fail++; $display("FAIL busy_wait: got early exit/drive/fail expected steady wait"); end
    tick();
    n_checks++;
    if (ch.tx_fail !== 1'b1 || ch.state_o !== 3'd1 || ch.trans_active !== 1'b0) begin
      n_fail++; $display("FAIL timeout_pulse: got fail %b state %0d ta %b expected 1 1 0", ch.tx_fail, ch.state_o, ch.trans_active);
    end
    tick();
    n_checks++;
    if (ch.tx_fail !== 1'b0 || ch.state_o !== 3'd2) begin
      n_fail++; $display("FAIL timeout_one_cycle: got fail %b state %0d expected 0 2", ch.tx_fail, ch.state_o);
    end
    ch.tx_req = 1'b0;
    tick();
    n_checks++;
    if (ch.tx_fail !== 1'b0 || ch.state_o !== 3'd1) begin
      n_fail++; $display("FAIL abort_no_fail: got fail %b state %0d expected 0 1", ch.tx_fail, ch.state_o);
    end
  endtask

  task automatic test_idle_vs_timeout();
    ch.sl_zeroes_in = 1'b0;
    repeat (2) tick();
    ch.tx_req = 1'b1;
    tick();
    repeat (1014) tick();
    ch.sl_zeroes_in = 1'b1;
    repeat (9) tick();
    n_checks++;
    if (ch.state_o !== 3'd2) begin n_fail++; $display("FAIL tie_pre: got %0d expected 2", ch.state_o); end
    tick();
    n_checks++;
    if (ch.state_o !== 3'd3 || ch.tx_fail !== 1'b0 || ch.trans_active !== 1'b1) begin
      n_fail++; $display("FAIL tie_idle_wins: got state %0d fail %b ta %b expected 3 0 1", ch.state_o, ch.tx_fail, ch.trans_active);
    end
    ch.tx_req = 1'b0;
    repeat (5) tick();
    n_checks++;
    if (ch.state_o !== 3'd1) begin n_fail++; $display("FAIL tie_back_listen: got %0d expected 1", ch.state_o); end
  endtask

  task automatic test_loopback();
    ch.loopback_en = 1'b1;
    tick();
    n_checks++;
    if (ch.state_o !== 3'd5 || {ch.trans_active, ch.rec_active, ch.tx_grant} !== 3'b111) begin
      n_fail++; $display("FAIL loop_entry: got state %0d sel %b expected 5 111", ch.state_o, {ch.trans_active, ch.rec_active, ch.tx_grant});
    end
    ch.tx_req = 1'b1;
    repeat (2) tick();
    n_checks++;
    if (ch.state_o !== 3'd5) begin n_fail++; $display("FAIL loop_hold: got %0d expected 5", ch.state_o); end
    ch.loopback_en = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (ch.state_o !== 3'd4 || {ch.trans_active, ch.rec_active, ch.tx_grant} !== 3'b000) begin
        n_fail++; $display("FAIL loop_guard[%0d]: got state %0d sel %b expected 4 000", i, ch.state_o, {ch.trans_active, ch.rec_active, ch.tx_grant});
      end
      tick();
    end
    n_checks++;
    if (ch.state_o !== 3'd2 || {ch.trans_active, ch.rec_active, ch.tx_grant} !== 3'b010) begin
      n_fail++; $display("FAIL loop_dispatch_tx: got state %0d sel %b expected 2 010", ch.state_o, {ch.trans_active, ch.rec_active, ch.tx_grant});
    end
    ch.tx_req = 1'b0;
    tick();
    n_checks++;
    if (ch.state_o !== 3'd1) begin n_fail++; $display("FAIL loop_back_listen: got %0d expected 1", ch.state_o); end
  endtask

  task automatic test_reset_mid_tx();
    ch.tx_req = 1'b1;
    tick();
    repeat (8) tick();
    ch.loopback_en = 1'b1;
    tick();
    n_checks++;
    if (ch.state_o !== 3'd3 || {ch.trans_active, ch.rec_active, ch.tx_grant} !== 3'b101) begin
      n_fail++; $display("FAIL tx_ignores_loop: got state %0d sel %b expected 3 101", ch.state_o, {ch.trans_active, ch.rec_active, ch.tx_grant});
    end
    rst_n = 1'b0;
    #2;
    n_checks++;
    if ({ch.trans_active, ch.rec_active, ch.tx_grant} !== 3'b000 || ch.state_o !== 3'd0) begin
      n_fail++; $display("FAIL async_reset: got state %0d sel %b expected 0 000", ch.state_o, {ch.trans_active, ch.rec_active, ch.tx_grant});
    end
    ch.tx_req = 1'b0; ch.loopback_en = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (ch.state_o !== 3'd1) begin n_fail++; $display("FAIL post_reset_listen: got %0d expected 1", ch.state_o); end
  endtask

  task automatic test_off();
    ch.rx_enable = 1'b0;
    tick();
    n_checks++;
    if (ch.state_o !== 3'd0 || {ch.trans_active, ch.rec_active, ch.tx_grant} !== 3'b000) begin
      n_fail++; $display("FAIL listen_to_off: got state %0d sel %b expected 0 000", ch.state_o, {ch.trans_active, ch.rec_active, ch.tx_grant});
    end
    ch.tx_req = 1'b1;
    tick();
    n_checks++;
    if (ch.state_o !== 3'd2 || ch.rec_active !== 1'b0) begin
      n_fail++; $display("FAIL wait_no_rx: got state %0d ra %b expected 2 0", ch.state_o, ch.rec_active);
    end
    ch.tx_req = 1'b0;
    tick();
    n_checks++;
    if (ch.state_o !== 3'd0) begin n_fail++; $display("FAIL abort_to_off: got %0d expected 0", ch.state_o); end
  endtask

  // Scenario sequence followed by the single summary line.
  initial begin
    test_reset();
    test_listen();
    test_tx();
    test_idle_restart();
    test_timeout();
    test_idle_vs_timeout();
    test_loopback();
    test_reset_mid_tx();
    test_off();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
